sd_block_arbiter: RTL and testbench
===================================

# sd_block_arbiter

Parametrised block-device request arbiter between the core's virtual drive controllers (floppy, HDD, SmartPort units) and the HPS `sd_rd`/`sd_wr`/`sd_ack` vectors. It replaces the single-drive read/write handshake in the top-level `emu` with an N-drive version. It adds per-drive pending latches, round-robin grant, LBA capture, mount/protect tracking, rejection of illegal requests, an ack timeout, and a shared `cpu_wait` stall output.

## Interface
- `NUM_DRIVES`, 2: number of drive channels (1..8); index i is the hps_io VD number.
- `TIMEOUT_CYCLES`, 0: maximum `clk_sys` cycles from request assert to `sd_ack` rise; 0 disables the timeout.
- `WAIT_ON_PENDING`, 1: 1 = `cpu_wait` also covers latched-but-ungranted requests; 0 = active transfer only.

- `clk_sys` in 1: system clock. All logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `drv_read` in N: 1-cycle read request pulse per drive.
- `drv_write` in N: 1-cycle write request pulse per drive.
- `drv_lba` in N*32: LBA per drive, sampled in the cycle of its request pulse.
- `img_mounted` in N: mount-event pulse per drive (from hps_io).
- `img_size` in 64: image size, valid with `img_mounted`.
- `img_readonly` in 1: read-only flag, valid with `img_mounted`.
- `sd_ack` in N: HPS acknowledge per drive.
- `sd_lba` out N*32: latched LBA per drive, to hps_io.
- `sd_rd` out N: read strobe per drive, to hps_io.
- `sd_wr` out N: write strobe per drive, to hps_io.
- `drv_mounted` out N: drive has an image with size != 0.
- `drv_protect` out N: drive image is read-only.
- `drv_busy` out N: drive has a pending or active request.
- `drv_done` out N: 1-cycle pulse when a transfer completes.
- `drv_error` out N: 1-cycle pulse on rejection or timeout.
- `cpu_wait` out 1: stall request to the CPU clock enable.

## Operation
- Reset values: all outputs 0, all pending bits 0, state IDLE, RR pointer 0.
- Request latch:
  - A `drv_read[i]` or `drv_write[i]` pulse sets `rd_pend[i]` or `wr_pend[i]` and captures `drv_lba[i]` into `sd_lba[i]`.
  - The capture is suppressed while drive i is the granted drive in REQ/XFER; the pending bit is still set.
- Rejection, checked at the pulse:
  - Request on a drive with `drv_mounted[i]`=0: no pending bit is set; `drv_error[i]` pulses.
  - Write on a drive with `drv_protect[i]`=1: no pending bit is set; `drv_error[i]` pulses.
- Mount: an `img_mounted[i]` pulse sets `drv_mounted[i]` <= (`img_size` != 0) and `drv_protect[i]` <= `img_readonly`. A mount event does not abort an active transfer.
- FSM states:
  - IDLE: if any pending bit is set, grant the first drive at or after the RR pointer with `rd_pend|wr_pend`. Read takes precedence over write on the same drive; the write stays pending. Assert `sd_rd[g]` or `sd_wr[g]`, go to REQ.
  - REQ: on `sd_ack[g]` rising edge, drop the strobe, clear the serviced pending bit, go to XFER. On timeout expiry, drop the strobe, clear the serviced bit, pulse `drv_error[g]`, go to IDLE.
  - XFER: on `sd_ack[g]` falling edge, pulse `drv_done[g]`, set RR pointer = g+1 mod N, go to IDLE.
- Edge detection uses a registered copy of `sd_ack`. Acks on non-granted drives are ignored.
- `drv_busy[i]` = `rd_pend[i]` | `wr_pend[i]` | (granted and state != IDLE).
- `cpu_wait`:
  - `WAIT_ON_PENDING`=1: (state != IDLE) | (|pending).
  - `WAIT_ON_PENDING`=0: (state != IDLE).
- Timeout counter: width $clog2(TIMEOUT_CYCLES+1). It clears on entry to REQ and saturates.

## Timing
- Request pulse at cycle t, arbiter IDLE: pending visible at t+1, strobe asserted at t+2, `cpu_wait` high from t+1.
- Ack rise sampled at t: strobe low at t+1.
- Ack fall sampled at t: `drv_done` high for cycle t+1 only, state IDLE at t+1. The next grant strobe appears no earlier than t+2.
- Request pulse in the same cycle as a grant to the same drive: re-latched as pending; served in a later grant.
- Simultaneous read+write pulse on one drive: both are latched; read is served first.
- Request pulse in the same cycle as `img_mounted` on that drive: checked against the pre-mount flags.
- `reset_n` low mid-transfer: strobes drop asynchronously, no `drv_done` or `drv_error` pulse, pending bits are lost.

## Structure
- Package `sd_arb_pkg`:
  - state enum `arb_state_t` {IDLE, REQ, XFER};
  - localparam `LBA_W`=32;
  - function `rr_pick(pend, ptr)` returning the grant index and a valid bit.
- One sub-module, `rr_arbiter`: a combinational N-way round-robin picker, reusable by other multi-channel blocks.
- The FSM, latches, timeout and mount tracking live in `sd_block_arbiter`.

## Test plan
- N=2, both drives mounted: read pulse on drive 1 with LBA 0x1234 → `sd_lba[1]`=0x1234, `sd_rd`=2'b10 two cycles later; ack high for 5 cycles → `drv_done[1]` one cycle after the ack falls; `cpu_wait` is high for the whole interval.
- Simultaneous read pulses on drives 0 and 1, RR pointer 0 → drive 0 served first, then drive 1. Repeat with the pointer at 1 → drive 1 served first.
- Drive 0 mounted with `img_readonly`=1: write pulse → `drv_error[0]` pulses, `sd_wr` stays 0, `cpu_wait` stays 0. Read pulse on unmounted drive 1 (`img_size`=0) → `drv_error[1]` pulses.
- `TIMEOUT_CYCLES`=16, ack never arrives → strobe drops after 16 cycles, `drv_error` pulses, state returns to IDLE.
- Read+write pulse together on drive 0 → `sd_rd` cycle, then `sd_wr` cycle, two `drv_done` pulses.
- `reset_n` low during XFER → all outputs 0 immediately; after release, a new request is served normally.

Source files
------------

// File: rtl/sd_arb_pkg.sv
// Shared types and helpers for the block-device request arbiter.
// Provides the FSM state type and a round-robin pick function for up to eight channels.
package sd_arb_pkg;

  localparam int unsigned LBA_W      = 32;
  localparam int unsigned MAX_DRIVES = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of pend at or after ptr, wrapping at n; ptr is assumed < n.
  function automatic rr_pick_t rr_pick(input logic [MAX_DRIVES-1:0] pend,
                                       input logic [2:0]            ptr,
                                       input int unsigned           n);
    rr_pick_t    res;
    int unsigned j;
    res = '0;
    for (int unsigned k = 0; k < MAX_DRIVES; k++) begin
      if (k < n) begin
        j = {29'd0, ptr} + k;
        if (j >= n) j = j - n;
        if (!res.valid && pend[j[2:0]]) begin
          res.valid = 1'b1;
          res.idx   = j[2:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way round-robin picker (N <= 8), reusable by multi-channel blocks.
// Grants the first requester at or after ptr_i.
module rr_arbiter
  import sd_arb_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  logic [MAX_DRIVES-1:0] req_ext;
  logic [2:0]            ptr_ext;
  rr_pick_t              pick;
  logic                  unused_idx;

  always_comb begin
    req_ext          = '0;
    req_ext[N-1:0]   = req_i;
    ptr_ext          = '0;
    ptr_ext[IW-1:0]  = ptr_i;
    pick             = rr_pick(req_ext, ptr_ext, N);
    valid_o          = pick.valid;
    idx_o            = pick.idx[IW-1:0];
  end

  assign unused_idx = ^pick.idx;

endmodule

// File: rtl/sd_block_arbiter.sv
// N-drive arbiter between virtual drive controllers and the HPS sd_rd/sd_wr/sd_ack handshake.
// Latches requests per drive, grants round-robin, tracks mount/protect, times out missing acks.
module sd_block_arbiter
  import sd_arb_pkg::*;
#(
  parameter int unsigned NUM_DRIVES      = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 0,
  parameter bit          WAIT_ON_PENDING = 1'b1
) (
  input  logic                          clk_sys,
  input  logic                          reset_n,
  input  logic [NUM_DRIVES-1:0]         drv_read,
  input  logic [NUM_DRIVES-1:0]         drv_write,
  input  logic [NUM_DRIVES*LBA_W-1:0]   drv_lba,
  input  logic [NUM_DRIVES-1:0]         img_mounted,
  input  logic [63:0]                   img_size,
  input  logic                          img_readonly,
  input  logic [NUM_DRIVES-1:0]         sd_ack,
  output logic [NUM_DRIVES*LBA_W-1:0]   sd_lba,
  output logic [NUM_DRIVES-1:0]         sd_rd,
  output logic [NUM_DRIVES-1:0]         sd_wr,
  output logic [NUM_DRIVES-1:0]         drv_mounted,
  output logic [NUM_DRIVES-1:0]         drv_protect,
  output logic [NUM_DRIVES-1:0]         drv_busy,
  output logic [NUM_DRIVES-1:0]         drv_done,
  output logic [NUM_DRIVES-1:0]         drv_error,
  output logic                          cpu_wait
);

  localparam int unsigned IW = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DRIVES - 1);

  arb_state_t                    state_q, state_d;
  logic [IW-1:0]                 grant_q, grant_d;
  logic [IW-1:0]                 ptr_q, ptr_d;
  logic [NUM_DRIVES-1:0]         rd_pend_q, rd_pend_d;
  logic [NUM_DRIVES-1:0]         wr_pend_q, wr_pend_d;
  logic [NUM_DRIVES*LBA_W-1:0]   lba_q, lba_d;
  logic [NUM_DRIVES-1:0]         mounted_q, mounted_d;
  logic [NUM_DRIVES-1:0]         protect_q, protect_d;
  logic [NUM_DRIVES-1:0]         ack_q;
  logic                          strobe_q, strobe_d;
  logic                          serv_wr_q, serv_wr_d;
  logic                          relatch_q, relatch_d;
  logic [TW-1:0]                 tmo_q, tmo_d;
  logic [NUM_DRIVES-1:0]         done_q, done_d;
  logic [NUM_DRIVES-1:0]         error_q, error_d;

  logic [NUM_DRIVES-1:0]         rd_ok, wr_ok, rejected, pend, grant_oh;
  logic                          pick_valid;
  logic [IW-1:0]                 pick_idx;
  logic                          ack_rise, ack_fall, tmo_expired;

  assign pend = rd_pend_q | wr_pend_q;

  rr_arbiter #(.N(NUM_DRIVES)) u_rr (
    .req_i   (pend),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // Requests are validated against the registered flags, i.e. before any same-cycle mount event.
  always_comb begin
    rd_ok    = drv_read & mounted_q;
    wr_ok    = drv_write & mounted_q & ~protect_q;
    rejected = (drv_read & ~mounted_q) | (drv_write & ~wr_ok);
    for (int unsigned i = 0; i < NUM_DRIVES; i++) begin
      grant_oh[i] = (grant_q == IW'(i));
    end
  end

  assign ack_rise    = |(sd_ack & ~ack_q & grant_oh);
  assign ack_fall    = |(~sd_ack & ack_q & grant_oh);
  assign tmo_expired = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST);

  always_comb begin
    mounted_d = mounted_q;
    protect_d = protect_q;
    for (int unsigned i = 0; i < NUM_DRIVES; i++) begin
      if (img_mounted[i]) begin
        mounted_d[i] = (img_size != 64'd0);
        protect_d[i] = img_readonly;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    strobe_d  = strobe_q;
    serv_wr_d = serv_wr_q;
    relatch_d = relatch_q;
    tmo_d     = tmo_q;
    done_d    = '0;
    error_d   = rejected;
    rd_pend_d = rd_pend_q | rd_ok;
    wr_pend_d = wr_pend_q | wr_ok;
    lba_d     = lba_q;

    for (int unsigned i = 0; i < NUM_DRIVES; i++) begin
      if ((rd_ok[i] || wr_ok[i]) && !((state_q != IDLE) && grant_oh[i])) begin
        lba_d[i*LBA_W +: LBA_W] = drv_lba[i*LBA_W +: LBA_W];
      end
    end

    // relatch remembers a same-type request on the granted drive that arrived after
    // its pending bit was already set, so the clear at ack/timeout does not swallow it.
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d   = pick_idx;
          serv_wr_d = ~rd_pend_q[pick_idx];
          relatch_d = rd_pend_q[pick_idx] ? rd_ok[pick_idx] : wr_ok[pick_idx];
          strobe_d  = 1'b1;
          tmo_d     = '0;
          state_d   = REQ;
        end
      end
      REQ: begin
        relatch_d = relatch_q | (|(grant_oh & (serv_wr_q ? wr_ok : rd_ok)));
        if (tmo_q != '1) tmo_d = tmo_q + TW'(1);
        if (ack_rise || tmo_expired) begin
          strobe_d = 1'b0;
          if (!relatch_d) begin
            if (serv_wr_q) wr_pend_d[grant_q] = 1'b0;
            else           rd_pend_d[grant_q] = 1'b0;
          end
          relatch_d = 1'b0;
          if (ack_rise) begin
            state_d = XFER;
          end else begin
            error_d[grant_q] = 1'b1;
            state_d          = IDLE;
          end
        end
      end
      XFER: begin
        if (ack_fall) begin
          done_d[grant_q] = 1'b1;
          ptr_d           = (grant_q == LAST_IDX) ? '0 : grant_q + IW'(1);
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      rd_pend_q <= '0;
      wr_pend_q <= '0;
      lba_q     <= '0;
      mounted_q <= '0;
      protect_q <= '0;
      ack_q     <= '0;
      strobe_q  <= 1'b0;
      serv_wr_q <= 1'b0;
      relatch_q <= 1'b0;
      tmo_q     <= '0;
      done_q    <= '0;
      error_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      rd_pend_q <= rd_pend_d;
      wr_pend_q <= wr_pend_d;
      lba_q     <= lba_d;
      mounted_q <= mounted_d;
      protect_q <= protect_d;
      ack_q     <= sd_ack;
      strobe_q  <= strobe_d;
      serv_wr_q <= serv_wr_d;
      relatch_q <= relatch_d;
      tmo_q     <= tmo_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign sd_lba      = lba_q;
  assign sd_rd       = (strobe_q && !serv_wr_q) ? grant_oh : '0;
  assign sd_wr       = (strobe_q &&  serv_wr_q) ? grant_oh : '0;
  assign drv_mounted = mounted_q;
  assign drv_protect = protect_q;
  assign drv_busy    = pend | ((state_q != IDLE) ? grant_oh : '0);
  assign drv_done    = done_q;
  assign drv_error   = error_q;
  assign cpu_wait    = (state_q != IDLE) || (WAIT_ON_PENDING && (|pend));

endmodule

// File: tb/tb_sd_block_arbiter.sv
// Directed self-checking bench for sd_block_arbiter with two drives and a 16-cycle ack timeout.
module tb_sd_block_arbiter;
  import sd_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  drv_read, drv_write, img_mounted, sd_ack;
  logic [63:0] drv_lba, img_size;
  logic        img_readonly;
  logic [63:0] sd_lba;
  logic [1:0]  sd_rd, sd_wr, drv_mounted, drv_protect, drv_busy, drv_done, drv_error;
  logic        cpu_wait;

  int total = 0;
  int bad   = 0;

  sd_block_arbiter #(
    .NUM_DRIVES      (2),
    .TIMEOUT_CYCLES  (16),
    .WAIT_ON_PENDING (1'b1)
  ) dut (
    .clk_sys      (clk),
    .reset_n      (reset_n),
    .drv_read     (drv_read),
    .drv_write    (drv_write),
    .drv_lba      (drv_lba),
    .img_mounted  (img_mounted),
    .img_size     (img_size),
    .img_readonly (img_readonly),
    .sd_ack       (sd_ack),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .drv_mounted  (drv_mounted),
    .drv_protect  (drv_protect),
    .drv_busy     (drv_busy),
    .drv_done     (drv_done),
    .drv_error    (drv_error),
    .cpu_wait     (cpu_wait)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mount(input logic [1:0] mask, input logic [63:0] size, input logic ro);
    img_mounted  = mask;
    img_size     = size;
    img_readonly = ro;
    tick();
    img_mounted  = 2'b00;
  endtask

  // Expects the strobe for 'oh' now; one-cycle ack, checks strobe drop and done pulse.
  task automatic serve(input string tag, input logic [1:0] oh, input bit wr);
    check({tag, "_strobe"}, {60'd0, sd_wr, sd_rd}, wr ? {60'd0, oh, 2'b00} : {62'd0, oh});
    sd_ack = oh;
    tick();
    check({tag, "_drop"}, {62'd0, sd_wr | sd_rd}, 64'd0);
    sd_ack = 2'b00;
    tick();
    check({tag, "_done"}, {62'd0, drv_done}, {62'd0, oh});
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; drv_read = '0; drv_write = '0; drv_lba = '0;
    img_mounted = '0; img_size = '0; img_readonly = 1'b0; sd_ack = '0;
    #3;
    check("rst_strobes", {60'd0, sd_rd, sd_wr}, 64'd0);
    check("rst_flags", {56'd0, drv_mounted, drv_protect, drv_busy, drv_done, drv_error}, 64'd0);
    check("rst_lba", sd_lba, 64'd0);
    check("rst_wait", {63'd0, cpu_wait}, 64'd0);
    tick();
    reset_n = 1'b1;
    tick();

    mount(2'b11, 64'd1000, 1'b0);
    check("mount_both", {60'd0, drv_mounted, drv_protect}, 64'b1100);

    // Read on drive 1, LBA 0x1234, five-cycle ack.
    drv_lba = {32'h0000_1234, 32'h0};
    drv_read = 2'b10;
    tick();
    drv_read = 2'b00;
    check("t1_lba", {32'd0, sd_lba[63:32]}, 64'h1234);
    check("t1_pend_strobe", {62'd0, sd_rd}, 64'd0);
    check("t1_pend_wait", {63'd0, cpu_wait}, 64'd1);
    check("t1_busy", {62'd0, drv_busy}, 64'b10);
    tick();
    check("t1_sd_rd", {62'd0, sd_rd}, 64'b10);
    check("t1_req_wait", {63'd0, cpu_wait}, 64'd1);
    sd_ack = 2'b10;
    tick();
    check("t1_drop", {62'd0, sd_rd}, 64'd0);
    check("t1_xfer_busy", {62'd0, drv_busy}, 64'b10);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t1_xfer_wait", {63'd0, cpu_wait}, 64'd1);
      check("t1_no_done", {62'd0, drv_done}, 64'd0);
    end
    sd_ack = 2'b00;
    tick();
    check("t1_done", {62'd0, drv_done}, 64'b10);
    check("t1_idle_wait", {63'd0, cpu_wait}, 64'd0);
    tick();
    check("t1_done_once", {62'd0, drv_done}, 64'd0);

    // Pointer is 0 after serving drive 1: drive 0 wins, then drive 1.
    drv_read = 2'b11;
    tick();
    drv_read = 2'b00;
    tick();
    serve("rr0_first", 2'b01, 1'b0);
    serve("rr0_second", 2'b10, 1'b0);

    // Move the pointer to 1, then the same contention serves drive 1 first.
    drv_read = 2'b01;
    tick();
    drv_read = 2'b00;
    tick();
    serve("rr_setup", 2'b01, 1'b0);
    drv_read = 2'b11;
    tick();
    drv_read = 2'b00;
    tick();
    serve("rr1_first", 2'b10, 1'b0);
    serve("rr1_second", 2'b01, 1'b0);

    // Write to read-only drive 0 and read on unmounted drive 1 are rejected.
    mount(2'b01, 64'd1000, 1'b1);
    check("ro_flags", {60'd0, drv_mounted, drv_protect}, 64'b1101);
    drv_write = 2'b01;
    tick();
    drv_write = 2'b00;
    check("ro_error", {62'd0, drv_error}, 64'b01);
    check("ro_wait", {63'd0, cpu_wait}, 64'd0);
    check("ro_busy", {62'd0, drv_busy}, 64'd0);
    tick();
    check("ro_no_wr", {62'd0, sd_wr}, 64'd0);
    check("ro_err_once", {62'd0, drv_error}, 64'd0);
    mount(2'b10, 64'd0, 1'b0);
    check("unmount", {62'd0, drv_mounted}, 64'b01);
    drv_read = 2'b10;
    tick();
    drv_read = 2'b00;
    check("um_error", {62'd0, drv_error}, 64'b10);
    check("um_wait", {63'd0, cpu_wait}, 64'd0);
    tick();
    check("um_no_rd", {62'd0, sd_rd}, 64'd0);

    // Ack never arrives: strobe held 16 cycles, then error and back to idle.
    mount(2'b11, 64'd4096, 1'b0);
    drv_read = 2'b01;
    tick();
    drv_read = 2'b00;
    tick();
    check("tmo_strobe", {62'd0, sd_rd}, 64'b01);
    for (int k = 0; k < 15; k++) begin
      tick();
      check("tmo_hold", {62'd0, sd_rd}, 64'b01);
    end
    tick();
    check("tmo_drop", {62'd0, sd_rd}, 64'd0);
    check("tmo_error", {62'd0, drv_error}, 64'b01);
    check("tmo_idle", {63'd0, cpu_wait}, 64'd0);
    tick();
    check("tmo_err_once", {62'd0, drv_error}, 64'd0);

    // Read and write together on drive 0: read first, then write.
    drv_read = 2'b01;
    drv_write = 2'b01;
    tick();
    drv_read = 2'b00;
    drv_write = 2'b00;
    check("rw_busy", {62'd0, drv_busy}, 64'b01);
    tick();
    serve("rw_read", 2'b01, 1'b0);
    serve("rw_write", 2'b01, 1'b1);
    check("rw_idle", {61'd0, cpu_wait, drv_busy}, 64'd0);

    // Asynchronous reset in XFER.
    drv_lba = {32'h0000_0077, 32'h0};
    drv_read = 2'b10;
    tick();
    drv_read = 2'b00;
    tick();
    check("rx_strobe", {62'd0, sd_rd}, 64'b10);
    sd_ack = 2'b10;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("rx_outputs", {53'd0, sd_rd, sd_wr, drv_busy, drv_done, drv_error, cpu_wait}, 64'd0);
    check("rx_lba", sd_lba, 64'd0);
    sd_ack = 2'b00;
    tick();
    reset_n = 1'b1;
    tick();
    check("rx_no_pulse", {60'd0, drv_done, drv_error}, 64'd0);
    mount(2'b11, 64'd1, 1'b0);
    drv_lba = {32'h0, 32'h0000_00AB};
    drv_read = 2'b01;
    tick();
    drv_read = 2'b00;
    check("rx_new_lba", {32'd0, sd_lba[31:0]}, 64'hAB);
    tick();
    serve("rx_after", 2'b01, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
